// File: rtl/multiport_registers_bank.sv
// General-purpose register file: N combinational read ports with write bypass, one write port,
// optional hardwired-zero r0, and a valid/ready dump engine that streams the whole bank out.
module multiport_registers_bank #(
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned NB_ADDR      = 5,
    parameter int unsigned BANK_DEPTH   = 32,
    parameter int unsigned N_READ_PORTS = 2,
    parameter int unsigned ZERO_REG     = 1
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_reg_write,
    input  logic [NB_ADDR-1:0]              i_write_reg,
    input  logic [NB_DATA-1:0]              i_write_data,
    input  logic [N_READ_PORTS*NB_ADDR-1:0] i_read_regs,
    output logic [N_READ_PORTS*NB_DATA-1:0] o_read_data,
    input  logic                            i_dump_start,
    input  logic                            i_dump_ready,
    output logic                            o_dump_valid,
    output logic [NB_ADDR-1:0]              o_dump_addr,
    output logic [NB_DATA-1:0]              o_dump_data,
    output logic                            o_dump_busy,
    output logic                            o_dump_done
);

    typedef enum logic [1:0] {StIdle, StDump, StDone} dump_state_e;

    localparam logic [NB_ADDR-1:0] LastPtr = NB_ADDR'(BANK_DEPTH - 1);

    logic [NB_DATA-1:0] bank_q [BANK_DEPTH];
    logic               write_en;
    logic               write_to_zero;

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] ptr_q, ptr_d;
    logic [NB_DATA-1:0] dump_word;

    always_comb begin
        write_en      = i_reg_write && !i_reset;
        write_to_zero = (ZERO_REG != 0) && (i_write_reg == '0);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < BANK_DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (i_reg_write && !write_to_zero) begin
            bank_q[i_write_reg] <= i_write_data;
        end
    end

    // Bypass lets decode see a value written back in the same cycle.
    for (genvar k = 0; k < N_READ_PORTS; k++) begin : g_read
        logic [NB_ADDR-1:0] rd_addr;
        assign rd_addr = i_read_regs[k*NB_ADDR +: NB_ADDR];

        always_comb begin
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                o_read_data[k*NB_DATA +: NB_DATA] = '0;
            end else if (write_en && (rd_addr == i_write_reg)) begin
                o_read_data[k*NB_DATA +: NB_DATA] = i_write_data;
            end else begin
                o_read_data[k*NB_DATA +: NB_DATA] = bank_q[rd_addr];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Dump shows stored contents only; bypass would report a write that has not landed yet.
    always_comb begin
        if ((ZERO_REG != 0) && (ptr_q == '0)) begin
            dump_word = '0;
        end else begin
            dump_word = bank_q[ptr_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        o_dump_valid = 1'b0;
        o_dump_addr  = '0;
        o_dump_data  = '0;
        o_dump_busy  = 1'b0;
        o_dump_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_dump_start) begin
                    state_d = StDump;
                    ptr_d   = '0;
                end
            end
            StDump: begin
                o_dump_valid = 1'b1;
                o_dump_busy  = 1'b1;
                o_dump_addr  = ptr_q;
                o_dump_data  = dump_word;
                if (i_dump_ready) begin
                    if (ptr_q == LastPtr) begin
                        state_d = StDone;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            StDone: begin
                o_dump_busy = 1'b1;
                o_dump_done = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_multiport_registers_bank.sv
// Directed bench: a default 2-port zero-reg bank plus a 4-port bank without the zero register,
// sharing clock, reset and write port.
module tb_multiport_registers_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic         reg_write;
    logic [4:0]   write_reg;
    logic [31:0]  write_data;
    logic [9:0]   rd_regs2;
    logic [63:0]  rd_data2;
    logic [19:0]  rd_regs4;
    logic [127:0] rd_data4;
    logic         dump_start;
    logic         dump_ready;
    logic         dump_valid;
    logic [4:0]   dump_addr;
    logic [31:0]  dump_data;
    logic         dump_busy;
    logic         dump_done;
    logic         d4_start;
    logic         d4_valid;
    logic [4:0]   d4_addr;
    logic [31:0]  d4_data;
    logic         d4_busy;
    logic         d4_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multiport_registers_bank #(
        .NB_DATA(32), .NB_ADDR(5), .BANK_DEPTH(32), .N_READ_PORTS(2), .ZERO_REG(1)
    ) u_dut (
        .i_clock(clk), .i_reset(reset), .i_reg_write(reg_write), .i_write_reg(write_reg),
        .i_write_data(write_data), .i_read_regs(rd_regs2), .o_read_data(rd_data2),
        .i_dump_start(dump_start), .i_dump_ready(dump_ready), .o_dump_valid(dump_valid),
        .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_busy(dump_busy),
        .o_dump_done(dump_done)
    );

    multiport_registers_bank #(
        .NB_DATA(32), .NB_ADDR(5), .BANK_DEPTH(32), .N_READ_PORTS(4), .ZERO_REG(0)
    ) u_dut4 (
        .i_clock(clk), .i_reset(reset), .i_reg_write(reg_write), .i_write_reg(write_reg),
        .i_write_data(write_data), .i_read_regs(rd_regs4), .o_read_data(rd_data4),
        .i_dump_start(d4_start), .i_dump_ready(1'b1), .o_dump_valid(d4_valid),
        .o_dump_addr(d4_addr), .o_dump_data(d4_data), .o_dump_busy(d4_busy),
        .o_dump_done(d4_done)
    );

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        @(posedge clk);
        #1 reg_write = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h55; rd_regs2 = {5'd0, 5'd10};
        #1;
        n_checks++;
        if (rd_data2[31:0] !== 32'h0) begin
            n_errors++; $display("FAIL reset_no_bypass: got %h want 0", rd_data2[31:0]);
        end
        @(posedge clk);
        #1 reg_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dump_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", dump_valid); end
        n_checks++;
        if (dump_addr !== 5'd0) begin n_errors++; $display("FAIL reset_addr: got %0d want 0", dump_addr); end
        n_checks++;
        if (dump_data !== 32'd0) begin n_errors++; $display("FAIL reset_data: got %h want 0", dump_data); end
        n_checks++;
        if (dump_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", dump_busy); end
        n_checks++;
        if (dump_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", dump_done); end
        n_checks++;
        if ({d4_valid, d4_busy, d4_done, d4_addr, d4_data} !== 40'd0) begin
            n_errors++; $display("FAIL reset_dut4_dump: got %b%b%b %h %h want all 0",
                                 d4_valid, d4_busy, d4_done, d4_addr, d4_data);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_data2 !== 64'd0) begin n_errors++; $display("FAIL reset_reads: got %h want 0", rd_data2); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'd99; rd_regs2 = {5'd0, 5'd10};
        #1;
        n_checks++;
        if (rd_data2[31:0] !== 32'd99) begin
            n_errors++; $display("FAIL bypass_r10: got %0d want 99", rd_data2[31:0]);
        end
        @(posedge clk);
        #1 reg_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_data2[31:0] !== 32'd99) begin
            n_errors++; $display("FAIL stored_r10: got %0d want 99", rd_data2[31:0]);
        end
        n_checks++;
        if (rd_data2[63:32] !== 32'd0) begin
            n_errors++; $display("FAIL stored_r0: got %0d want 0", rd_data2[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'd111;
        rd_regs2 = {5'd0, 5'd0}; rd_regs4 = 20'd0;
        #1;
        n_checks++;
        if (rd_data2 !== 64'd0) begin n_errors++; $display("FAIL zero_same_cycle: got %h want 0", rd_data2); end
        n_checks++;
        if (rd_data4[31:0] !== 32'd111) begin
            n_errors++; $display("FAIL nozero_bypass: got %0d want 111", rd_data4[31:0]);
        end
        @(posedge clk);
        #1 reg_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_data2 !== 64'd0) begin n_errors++; $display("FAIL zero_next_cycle: got %h want 0", rd_data2); end
        n_checks++;
        if (rd_data4[127:96] !== 32'd111) begin
            n_errors++; $display("FAIL nozero_stored: got %0d want 111", rd_data4[127:96]);
        end
    endtask

    task automatic test_four_ports();
        do_write(5'd1, 32'd555);
        do_write(5'd2, 32'd7);
        do_write(5'd31, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_regs4 = {5'd1, 5'd31, 5'd2, 5'd1};
        rd_regs2 = {5'd2, 5'd31};
        #1;
        n_checks++;
        if (rd_data4 !== {32'd555, 32'hFFFF_FFFF, 32'd7, 32'd555}) begin
            n_errors++; $display("FAIL four_ports: got %h want 0000022bffffffff000000070000022b",
                                 rd_data4);
        end
        n_checks++;
        if (rd_data2 !== {32'd7, 32'hFFFF_FFFF}) begin
            n_errors++; $display("FAIL two_ports: got %h want 00000007ffffffff", rd_data2);
        end
    endtask

    task automatic test_dump_full();
        logic [31:0] exp;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i + 100));
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp = (i == 0) ? 32'd0 : 32'(i + 100);
            n_checks++;
            if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0) begin
                n_errors++; $display("FAIL dump_word%0d_flags: got v%b b%b d%b want v1 b1 d0",
                                     i, dump_valid, dump_busy, dump_done);
            end
            n_checks++;
            if (dump_addr !== 5'(i) || dump_data !== exp) begin
                n_errors++; $display("FAIL dump_word%0d: got %0d/%0d want %0d/%0d",
                                     i, dump_addr, dump_data, i, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
            n_errors++; $display("FAIL dump_done_pulse: got d%b v%b b%b want d1 v0 b1",
                                 dump_done, dump_valid, dump_busy);
        end
        @(negedge clk);
        n_checks++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            n_errors++; $display("FAIL dump_back_idle: got d%b b%b want d0 b0", dump_done, dump_busy);
        end
    endtask

    task automatic test_dump_toggle();
        int          n_dump = 0;
        int          next_addr = 0;
        bit          seen_done = 1'b0;
        logic [31:0] exp;
        @(negedge clk);
        dump_start = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk);
            if (dump_done) begin
                seen_done = 1'b1;
            end else if (dump_valid) begin
                exp = (next_addr == 0) ? 32'd0 : 32'(next_addr + 100);
                n_checks++;
                if (dump_addr !== 5'(next_addr) || dump_data !== exp) begin
                    n_errors++; $display("FAIL toggle_cycle%0d: got %0d/%0d want %0d/%0d",
                                         n_dump, dump_addr, dump_data, next_addr, exp);
                end
                dump_ready = (n_dump % 2 == 0);
                dump_start = (n_dump == 20);
                if (dump_ready) next_addr++;
                n_dump++;
            end
        end
        dump_start = 1'b0;
        dump_ready = 1'b1;
        n_checks++;
        if (!seen_done || n_dump != 63 || next_addr != 32) begin
            n_errors++; $display("FAIL toggle_totals: got done=%0d cycles=%0d words=%0d want 1/63/32",
                                 seen_done, n_dump, next_addr);
        end
        @(negedge clk);
        n_checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            n_errors++; $display("FAIL toggle_idle: got b%b v%b want b0 v0", dump_busy, dump_valid);
        end
        @(negedge clk);
        n_checks++;
        if (dump_valid !== 1'b0) begin
            n_errors++; $display("FAIL toggle_no_restart: got v%b want v0", dump_valid);
        end
    endtask

    task automatic test_reset_mid_dump();
        bit found = 1'b0;
        int n_done = 0;
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b1;
        @(posedge clk);
        #1 dump_start = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (dump_valid && dump_addr == 5'd12) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL mid_reach_word12: got none want word 12"); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_addr !== 5'd0) begin
            n_errors++; $display("FAIL mid_reset_state: got v%b b%b a%0d want v0 b0 a0",
                                 dump_valid, dump_busy, dump_addr);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dump_done) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin n_errors++; $display("FAIL mid_no_done: got %0d pulses want 0", n_done); end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_regs2 = {5'(31 - i), 5'(i)};
            rd_regs4 = {5'(i), 5'(i), 5'(i), 5'(i)};
            #1;
            n_checks++;
            if (rd_data2 !== 64'd0 || rd_data4 !== 128'd0) begin
                n_errors++; $display("FAIL mid_cleared_r%0d: got %h %h want 0", i, rd_data2, rd_data4);
            end
        end
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        rd_regs2 = '0; rd_regs4 = '0; dump_start = 1'b0; dump_ready = 1'b0; d4_start = 1'b0;
        @(posedge clk);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_four_ports();
        test_dump_full();
        test_dump_toggle();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multiport_registers_bank.md
# multiport_registers_bank

Parametrised general-purpose register file for the pipelined MIPS datapath, successor of the two-read-port bank used in the decode stage. It provides N combinational read ports with same-cycle write-to-read bypass, one synchronous write port, an optional hardwired-zero register 0, and a sequential dump engine that streams every register out over a valid/ready handshake for the debug unit.

## Interface
- NB_DATA, 32, register width in bits
- NB_ADDR, 5, register address width
- BANK_DEPTH, 32, number of registers; must equal 2**NB_ADDR
- N_READ_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- i_clock  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_reg_write  in  1  write enable
- i_write_reg  in  NB_ADDR  write address
- i_write_data  in  NB_DATA  write data
- i_read_regs  in  N_READ_PORTS*NB_ADDR  read addresses; port k at [k*NB_ADDR +: NB_ADDR]
- o_read_data  out  N_READ_PORTS*NB_DATA  read data; port k at [k*NB_DATA +: NB_DATA]
- i_dump_start  in  1  request a full-bank dump (level-sampled in IDLE only)
- i_dump_ready  in  1  consumer accepts the current dump word
- o_dump_valid  out  1  dump word valid
- o_dump_addr  out  NB_ADDR  register index of current dump word
- o_dump_data  out  NB_DATA  stored value of register o_dump_addr
- o_dump_busy  out  1  high in DUMP and DONE states
- o_dump_done  out  1  one-cycle pulse after last word transferred

## Operation
- Write: on rising edge with i_reg_write=1 and i_reset=0, bank[i_write_reg] <= i_write_data; if ZERO_REG=1 and i_write_reg=0, write dropped.
- Read (combinational, per port k): if ZERO_REG=1 and addr=0 -> 0; else if i_reg_write=1, i_reset=0 and addr=i_write_reg -> i_write_data (bypass); else bank[addr].
- Several ports may read the same address; all see identical data.
- Reset: every bank entry cleared to 0 at the edge; while i_reset=1 writes and bypass are disabled, reads return stored (cleared) values.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: busy=0, valid=0, addr=0. i_dump_start=1 -> DUMP, dump pointer 0.
  - DUMP: valid=1, o_dump_addr=pointer, o_dump_data=stored bank[pointer] (zero rule applies, no bypass; reflects writes completed at earlier edges). On edge with i_dump_ready=1: pointer==BANK_DEPTH-1 -> DONE, else pointer+1. i_dump_ready=0 holds pointer (data may change if register is written meanwhile).
  - DONE: valid=0, done=1, busy=1 for one cycle -> IDLE.
- i_dump_start outside IDLE ignored; no queued restart.
- Normal reads/writes are fully independent of the dump and never stall.

## Timing
- Read latency 0 cycles (combinational from addresses and write inputs).
- Write visible to stored reads the cycle after the write edge; visible same cycle via bypass.
- Dump: start sampled edge T -> first valid word cycle T+1; with i_dump_ready held 1, word i valid in cycle T+1+i, done pulse in cycle T+1+BANK_DEPTH, IDLE again T+2+BANK_DEPTH (restart possible from that cycle).
- Reset values: bank all 0, FSM IDLE, o_dump_valid=0, o_dump_addr=0, o_dump_data=0, o_dump_busy=0, o_dump_done=0; o_read_data=0 for every port.
- Reset mid-dump: next cycle FSM IDLE, pointer 0, no done pulse.
- Pointer never wraps in DUMP; exit only through DONE.

## Test plan
- Reset then write 99 to r10, next cycle read ports 0/1 = r10/r0 -> 99 / 0; read r10 during the write cycle -> 99 via bypass.
- ZERO_REG=1: write 111 to r0, read r0 on all ports same and next cycle -> 0; ZERO_REG=0 build -> 111 next cycle.
- N_READ_PORTS=4: write r1=555, r2=7, r31=0xFFFFFFFF; ports read r1,r2,r31,r1 -> 555,7,0xFFFFFFFF,555.
- Dump with ready=1 after loading r_i=i+100 (i>0): 32 words, addr 0..31, data 0,101..131, done pulse exactly one cycle after word 31.
- Dump with ready toggling 1/0 every cycle: each address appears, none skipped or duplicated on accepted transfers; total 63 DUMP cycles; i_dump_start pulsed mid-dump ignored.
- Assert i_reset at dump word 12: next cycle valid=0, busy=0, done never pulses, all registers read 0.
